// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - serial link input and framed parallel output bundle
//
// Carries the serial link (serial_in, serial_en) into the receiver and the received
// frame (par_out, out_valid, out_ready) out of it.
//   master : transmitter / consumer side (drives serial_in, serial_en, out_ready)
//   slave  : receiver side (drives par_out, out_valid)
//   serial_in   1                        serial data, LSB-first, word 0 first
//   serial_en   1                        frame envelope from the transmitter
//   par_out     DATA_DEPTH x DATA_WIDTH  received frame, [word][bit]
//   out_valid   1                        par_out holds an unconsumed frame
//   out_ready   1                        consumer accepts par_out
interface serial_frame_receiver_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 4
);
    logic                                  serial_in;
    logic                                  serial_en;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out;
    logic                                  out_valid;
    logic                                  out_ready;

    modport master (
        output serial_in,
        output serial_en,
        output out_ready,
        input  par_out,
        input  out_valid
    );

    modport slave (
        input  serial_in,
        input  serial_en,
        input  out_ready,
        output par_out,
        output out_valid
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - P_FEC serial link frame receiver with valid/ready output buffer
//
// Captures (depth+1) words of (width+1) bits, LSB-first, word 0 first, each bit held
// for clk_div+1 cycles while serial_en is high, and presents the frame on par_out.
// Optional build macro: RX_SYNC_EN - adds a 2-flop synchronizer on serial_in and
// serial_en (frame start, sample points and out_valid all move 2 cycles later).
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   enable         arms frame start detection (does not abort a frame in progress)
//   clk_div        bit period minus 1, in clk cycles
//   width          bits per word minus 1 (clamped to DATA_WIDTH-1)
//   depth          words per frame minus 1 (clamped to DATA_DEPTH-1)
//   bus            slave modport: serial_in, serial_en, par_out, out_valid, out_ready
//   busy           receiver is in the middle of a frame
//   frame_err      1-cycle pulse: serial_en dropped mid-frame
//   overrun        1-cycle pulse: completed frame dropped because the buffer was full
//   bit_count      current bit index
//   sample_count   current word index
module serial_frame_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic [$clog2(DATA_WIDTH):0]   width,
    input  logic [$clog2(DATA_DEPTH):0]   depth,
    serial_frame_receiver_if.slave        bus,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(DATA_WIDTH):0]   bit_count,
    output logic [$clog2(DATA_DEPTH):0]   sample_count
);
    localparam int CW  = $clog2(DATA_WIDTH) + 1;
    localparam int CD  = $clog2(DATA_DEPTH) + 1;
    localparam int BIW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DIW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    localparam logic [CW-1:0] W_MAX = CW'(DATA_WIDTH - 1);
    localparam logic [CD-1:0] D_MAX = CD'(DATA_DEPTH - 1);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t                                state;
    logic                                  ser_in;
    logic                                  ser_en;
    logic                                  ser_en_d;
    logic [DIV_WIDTH-1:0]                  div_r;
    logic [CW-1:0]                         width_r;
    logic [CD-1:0]                         depth_r;
    logic [DIV_WIDTH-1:0]                  phase_r;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_q;
    logic                                  valid_q;

`ifdef RX_SYNC_EN
    logic [1:0] sync_in;
    logic [1:0] sync_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_in <= '0;
            sync_en <= '0;
        end else begin
            sync_in <= {sync_in[0], bus.serial_in};
            sync_en <= {sync_en[0], bus.serial_en};
        end
    end

    assign ser_in = sync_in[1];
    assign ser_en = sync_en[1];
`else
    assign ser_in = bus.serial_in;
    assign ser_en = bus.serial_en;
`endif

    // The start cycle is already bit 0 / phase 0 of the frame, so it must be able to
    // take a sample (clk_div <= 1) or even complete a 1-bit frame. The "cur_*" and
    // "eff_*" views therefore use live inputs in IDLE and the latched copies in RECEIVE.
    logic                                  start;
    logic                                  in_rx;
    logic                                  abort;
    logic [DIV_WIDTH-1:0]                  eff_div;
    logic [CW-1:0]                         eff_width;
    logic [CD-1:0]                         eff_depth;
    logic [DIV_WIDTH-1:0]                  cur_phase;
    logic [CW-1:0]                         cur_bit;
    logic [CD-1:0]                         cur_word;
    logic                                  sample;
    logic                                  last_bit;
    logic                                  last_sample;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow_next;

    always_comb begin
        start       = (state == IDLE) && enable && ser_en && !ser_en_d;
        in_rx       = (state == RECEIVE);
        abort       = in_rx && !ser_en;
        eff_div     = in_rx ? div_r : clk_div;
        eff_width   = in_rx ? width_r : ((width > W_MAX) ? W_MAX : width);
        eff_depth   = in_rx ? depth_r : ((depth > D_MAX) ? D_MAX : depth);
        cur_phase   = in_rx ? phase_r : '0;
        cur_bit     = in_rx ? bit_count : '0;
        cur_word    = in_rx ? sample_count : '0;
        sample      = (start || (in_rx && ser_en)) && (cur_phase == (eff_div >> 1));
        last_bit    = (cur_bit == eff_width);
        last_sample = sample && last_bit && (cur_word == eff_depth);
        // A fresh frame starts from an all-zero shadow so unused bits/words read 0.
        shadow_next = in_rx ? shadow : '0;
        if (sample) begin
            shadow_next[cur_word[DIW-1:0]][cur_bit[BIW-1:0]] = ser_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ser_en_d     <= 1'b0;
            div_r        <= '0;
            width_r      <= '0;
            depth_r      <= '0;
            phase_r      <= '0;
            shadow       <= '0;
            par_q        <= '0;
            valid_q      <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            bit_count    <= '0;
            sample_count <= '0;
        end else begin
            ser_en_d  <= ser_en;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (abort) begin
                state        <= IDLE;
                busy         <= 1'b0;
                frame_err    <= 1'b1;
                phase_r      <= '0;
                bit_count    <= '0;
                sample_count <= '0;
            end else if (start || in_rx) begin
                if (start) begin
                    div_r   <= eff_div;
                    width_r <= eff_width;
                    depth_r <= eff_depth;
                end
                shadow  <= shadow_next;
                phase_r <= (cur_phase == eff_div) ? '0 : cur_phase + 1'b1;

                if (last_sample) begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    phase_r      <= '0;
                    bit_count    <= '0;
                    sample_count <= '0;
                    // The commit uses shadow_next so the final bit lands in par_out on
                    // the same edge that takes the sample.
                    if (valid_q && !bus.out_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        par_q   <= shadow_next;
                        valid_q <= 1'b1;
                    end
                end else begin
                    state <= RECEIVE;
                    busy  <= 1'b1;
                    if (start) begin
                        bit_count    <= '0;
                        sample_count <= '0;
                    end
                    if (sample) begin
                        if (last_bit) begin
                            bit_count    <= '0;
                            sample_count <= cur_word + 1'b1;
                        end else begin
                            bit_count    <= cur_bit + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.par_out   = par_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - randomized self-checking bench for serial_frame_receiver
module tb_serial_frame_receiver;
    localparam int DW  = 32;
    localparam int DD  = 4;
    localparam int DVW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] clk_div = '0;
    logic [5:0] width = '0;
    logic [2:0] depth = '0;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic [5:0] bit_count;
    logic [2:0] sample_count;

    serial_frame_receiver_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) sif ();

    serial_frame_receiver #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .DIV_WIDTH(DVW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clk_div      (clk_div),
        .width        (width),
        .depth        (depth),
        .bus          (sif),
        .busy         (busy),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .bit_count    (bit_count),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          ov_rise = 0;
    logic        ov_q = 1'b0;
    int          fe_cnt = 0;
    int          ovr_cnt = 0;
    int          busy_cnt = 0;
    logic [31:0] tx_words [4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sif.out_valid && !ov_q) ov_rise <= cyc;
        ov_q <= sif.out_valid;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int words_of(input int d_in);
        return (d_in > DD - 1) ? DD : d_in + 1;
    endfunction

    function automatic int bits_of(input int w_in);
        return (w_in > DW - 1) ? DW : w_in + 1;
    endfunction

    function automatic int exp_lat(input int w_in, input int d_in, input int cd);
        return (bits_of(w_in) * words_of(d_in) - 1) * (cd + 1) + cd / 2 + 1;
    endfunction

    function automatic logic [127:0] exp_frame(input int w_in, input int d_in);
        logic [63:0]  m;
        logic [127:0] f;
        m = (64'd1 << bits_of(w_in)) - 64'd1;
        f = '0;
        for (int i = 0; i < words_of(d_in); i++) f[i*32 +: 32] = tx_words[i] & m[31:0];
        return f;
    endfunction

    // Behavioural serializer: nbits < 0 sends the whole frame, otherwise stops early.
    task automatic send_frame(input int w_in, input int d_in, input int cd, input int nbits,
                              input bit scramble);
        int wc;
        int total;
        wc    = bits_of(w_in);
        total = wc * words_of(d_in);
        if (nbits >= 0 && nbits < total) total = nbits;
        width   = w_in[5:0];
        depth   = d_in[2:0];
        clk_div = cd[7:0];
        t_start = cyc;
        for (int k = 0; k < total; k++) begin
            sif.serial_en = 1'b1;
            sif.serial_in = tx_words[k / wc][k % wc];
            repeat (cd + 1) begin
                @(negedge clk);
                if (scramble) begin
                    enable  = 1'b0;
                    width   = 6'($urandom);
                    depth   = 3'($urandom);
                    clk_div = 8'($urandom);
                end
            end
        end
        sif.serial_en = 1'b0;
        sif.serial_in = 1'b0;
        enable        = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic consume(input string tag);
        sif.out_ready = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0;
        check({tag, " consumed"}, sif.out_valid, 1'b0);
    endtask

    task automatic run_frame(input string tag, input int w_in, input int d_in, input int cd,
                             input bit scramble);
        send_frame(w_in, d_in, cd, -1, scramble);
        check({tag, " latency"}, ov_rise - t_start, exp_lat(w_in, d_in, cd));
        check({tag, " data"}, sif.par_out, exp_frame(w_in, d_in));
        check({tag, " valid"}, sif.out_valid, 1'b1);
        consume(tag);
    endtask

    initial begin
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        int           base;
        int           cd;
        int           w_in;
        int           d_in;

        sif.serial_in = 1'b0;
        sif.serial_en = 1'b0;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset par_out", sif.par_out, '0);
        check("reset out_valid", sif.out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset pulses", {frame_err, overrun}, 2'b00);
        check("reset counters", {bit_count, sample_count}, '0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        tx_words = '{32'h000000A5, 32'h0, 32'h0, 32'h0};
        run_frame("byte", 7, 0, 0, 1'b0);

        tx_words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        run_frame("full", 31, 3, 3, 1'b0);

        base = fe_cnt;
        cd   = $urandom_range(0, 3);
        tx_words = '{$urandom, $urandom, 32'h0, 32'h0};
        send_frame(15, 1, cd, 10, 1'b0);
        check("abort frame_err", fe_cnt - base, 1);
        check("abort out_valid", sif.out_valid, 1'b0);
        check("abort busy", busy, 1'b0);
        tx_words = '{$urandom, $urandom, 32'h0, 32'h0};
        run_frame("after abort", 15, 1, cd, 1'b0);

        tx_words = '{$urandom, $urandom, 32'h0, 32'h0};
        exp_a = exp_frame(7, 1);
        send_frame(7, 1, 2, -1, 1'b0);
        check("ovr first", sif.par_out, exp_a);
        base = ovr_cnt;
        tx_words = '{$urandom, $urandom, 32'h0, 32'h0};
        send_frame(7, 1, 2, -1, 1'b0);
        check("ovr pulse", ovr_cnt - base, 1);
        check("ovr kept", sif.par_out, exp_a);
        check("ovr valid", sif.out_valid, 1'b1);
        consume("ovr");

        tx_words = '{$urandom, $urandom, 32'h0, 32'h0};
        send_frame(7, 1, 2, -1, 1'b0);
        tx_words = '{$urandom, $urandom, 32'h0, 32'h0};
        exp_b = exp_frame(7, 1);
        base  = ovr_cnt;
        fork
            send_frame(7, 1, 2, -1, 1'b0);
            begin
                repeat (exp_lat(7, 1, 2) - 1) @(negedge clk);
                sif.out_ready = 1'b1;
                @(negedge clk);
                sif.out_ready = 1'b0;
                check("same-cycle valid", sif.out_valid, 1'b1);
            end
        join
        check("same-cycle data", sif.par_out, exp_b);
        check("same-cycle no ovr", ovr_cnt - base, 0);

        tx_words = '{$urandom, $urandom, $urandom, $urandom};
        width    = 6'd7;
        depth    = 3'd3;
        clk_div  = 8'd1;
        for (int k = 0; k < 13; k++) begin
            sif.serial_en = 1'b1;
            sif.serial_in = tx_words[k / 8][k % 8];
            repeat (2) @(negedge clk);
        end
        check("mid busy", busy, 1'b1);
        check("mid bit_count", bit_count, 6'd5);
        check("mid sample_count", sample_count, 3'd1);
        rst_n = 1'b0;
        sif.serial_en = 1'b0;
        #1;
        check("async rst busy", busy, 1'b0);
        check("async rst counters", {bit_count, sample_count}, '0);
        check("async rst valid", sif.out_valid, 1'b0);
        check("async rst par_out", sif.par_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame("post reset", 7, 3, 1, 1'b0);

        enable = 1'b0;
        base   = busy_cnt;
        repeat (4) begin
            sif.serial_en = 1'b1;
            repeat (3) @(negedge clk);
            sif.serial_en = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("disabled busy", busy_cnt - base, 0);
        check("disabled valid", sif.out_valid, 1'b0);
        enable = 1'b1;

        for (int n = 0; n < 100; n++) begin
            tx_words = '{$urandom, $urandom, $urandom, $urandom};
            w_in = $urandom_range(0, 35);
            d_in = $urandom_range(0, 4);
            cd   = $urandom_range(0, 3);
            run_frame("random", w_in, d_in, cd, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
